// File: rtl/robm_pkg.sv
// Shared state encoding, default sizes and the key parity helper for the key-load controller.
// The PAR/ERR states exist only when ROBM_KEY_PARITY_EN is defined.
package robm_pkg;

  localparam int unsigned KeyWDefault     = 8;
  localparam int unsigned MaxTriesDefault = 3;
  localparam int unsigned HoldCycDefault  = 4;
  localparam int unsigned ParityMaxW      = 64;

`ifdef ROBM_KEY_PARITY_EN
  typedef enum logic [2:0] {
    StIdle, StLoad, StPar, StHold, StRun, StErr, StLockout
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLoad, StHold, StRun, StLockout
  } state_e;
`endif

  // True when key plus parity bit carry an even number of ones (unused upper bits are zero).
  function automatic logic even_parity_ok(input logic [ParityMaxW-1:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/robm_key_shreg.sv
// Serial MSB-first key shift register with accepted-bit counter; updates on the falling edge.
module robm_key_shreg #(
  parameter int unsigned KeyW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            shift_i,
  input  logic            bit_i,
  output logic [KeyW-1:0] data_o,
  output logic            done_o
);

  localparam int unsigned CntW = $clog2(KeyW + 1);

  logic [KeyW-1:0] data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = {data_q[KeyW-2:0], bit_i};
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  // Set while the next accepted bit is the last one of the key.
  assign done_o = (cnt_q == CntW'(KeyW - 1));

endmodule

// File: rtl/robm_key_ctrl.sv
// Key-load controller: serially loads a key, holds the locked controller in reset, then runs it.
// Define ROBM_KEY_PARITY_EN to add the even-parity check (PAR and ERR states, err output).
module robm_key_ctrl
  import robm_pkg::*;
#(
  parameter int unsigned KEY_W     = KeyWDefault,
  parameter int unsigned MAX_TRIES = MaxTriesDefault,
  parameter int unsigned HOLD_CYC  = HoldCycDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             fsm_rst,
  output logic             active,
  output logic             err,
  output logic             lockout
);

  localparam int unsigned TryW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);

  state_e             state_q, state_d;
  logic [TryW-1:0]    try_cnt_q, try_cnt_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               fsm_rst_q, fsm_rst_d;
  logic               key_ready_q, key_ready_d;
  logic               active_q, active_d;
  logic               lockout_q, lockout_d;

  logic               shreg_clr, shreg_shift, shreg_done;
  logic [KEY_W-1:0]   shreg;
  logic [KEY_W-1:0]   key_full;

  robm_key_shreg #(
    .KeyW(KEY_W)
  ) u_shreg (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (shreg_clr),
    .shift_i(shreg_shift),
    .bit_i  (key_bit),
    .data_o (shreg),
    .done_o (shreg_done)
  );

  // Key including the bit being accepted this cycle, for the direct LOAD->HOLD path.
  assign key_full = {shreg[KEY_W-2:0], key_bit};

  always_comb begin
    state_d     = state_q;
    try_cnt_d   = try_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    shreg_clr   = 1'b0;
    shreg_shift = 1'b0;
    unique case (state_q)
      StIdle,
`ifdef ROBM_KEY_PARITY_EN
      StErr,
`endif
      StRun: begin
        if (start) begin
          if (try_cnt_q == TryW'(MAX_TRIES)) begin
            state_d = StLockout;
          end else begin
            state_d   = StLoad;
            shreg_clr = 1'b1;
            try_cnt_d = try_cnt_q + TryW'(1);
          end
        end
      end
      StLoad: begin
        if (abort) begin
          state_d   = StIdle;
          shreg_clr = 1'b1;
        end else if (key_valid) begin
          shreg_shift = 1'b1;
          if (shreg_done) begin
`ifdef ROBM_KEY_PARITY_EN
            state_d = StPar;
`else
            state_d    = StHold;
            hold_cnt_d = '0;
`endif
          end
        end
      end
`ifdef ROBM_KEY_PARITY_EN
      StPar: begin
        if (abort) begin
          state_d   = StIdle;
          shreg_clr = 1'b1;
        end else if (key_valid) begin
          if (even_parity_ok(ParityMaxW'({shreg, key_bit}))) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
`endif
      StHold: begin
        if (hold_cnt_q == HoldW'(HOLD_CYC - 1)) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StLockout: state_d = StLockout;
      default:   state_d = StIdle;
    endcase
  end

`ifdef ROBM_KEY_PARITY_EN
  logic err_q, err_d;
`endif

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    key_out_d = key_out_q;
    if (state_d == StLockout) begin
      key_out_d = '0;
    end else if (state_d == StHold && state_q != StHold) begin
      key_out_d = (state_q == StLoad) ? key_full : shreg;
    end
    fsm_rst_d   = (state_d != StRun);
    active_d    = (state_d == StRun);
    lockout_d   = (state_d == StLockout);
    key_ready_d = (state_d == StLoad);
`ifdef ROBM_KEY_PARITY_EN
    key_ready_d = key_ready_d || (state_d == StPar);
    err_d       = (state_d == StErr);
`endif
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      try_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      key_out_q   <= '0;
      fsm_rst_q   <= 1'b1;
      key_ready_q <= 1'b0;
      active_q    <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      try_cnt_q   <= try_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      key_out_q   <= key_out_d;
      fsm_rst_q   <= fsm_rst_d;
      key_ready_q <= key_ready_d;
      active_q    <= active_d;
      lockout_q   <= lockout_d;
    end
  end

`ifdef ROBM_KEY_PARITY_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign key_ready = key_ready_q;
  assign key_out   = key_out_q;
  assign fsm_rst   = fsm_rst_q;
  assign active    = active_q;
  assign lockout   = lockout_q;

endmodule

// File: doc/robm_key_ctrl.md
ROBM_KEY_CTRL -- requirements
Module: robm_key_ctrl

Interface
REQ-001 Parameter KEY_W, default 8: number of key bits delivered to the locked controller.
REQ-002 Parameter MAX_TRIES, default 3: number of key-load sessions permitted before permanent lockout.
REQ-003 Parameter HOLD_CYC, default 4: clock cycles the locked controller is held in reset after a key is applied.
REQ-004 clk  input  1  clock; all state updates occur on the falling edge, matching the locked controller.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  request a key-load session.
REQ-007 abort  input  1  cancel a session in progress.
REQ-008 key_valid  input  1  serial key bit is valid.
REQ-009 key_bit  input  1  serial key data, MSB first.
REQ-010 key_ready  output  1  controller accepts a key bit this cycle.
REQ-011 key_out  output  KEY_W  key bus to the locked controller's keyinput ports.
REQ-012 fsm_rst  output  1  active-high reset to the locked controller.
REQ-013 active  output  1  the locked controller is running with an applied key.
REQ-014 err  output  1  the last session failed its parity check.
REQ-015 lockout  output  1  the try budget is exhausted; sticky.

Function
REQ-016 States SHALL be IDLE, LOAD, PAR, HOLD, RUN, ERR and LOCKOUT; the state register and every output SHALL be registered.
REQ-017 IDLE: start SHALL cause a transition to LOAD, clear the shift register and bit counter, and increment try_cnt.
REQ-018 LOAD: key_ready=1; each cycle with key_valid=1, shreg SHALL become {shreg[KEY_W-2:0], key_bit} and the bit counter SHALL increment.
REQ-019 LOAD: acceptance of bit KEY_W-1 SHALL cause a transition to PAR when KEY_PARITY_EN is defined, else to HOLD.
REQ-020 PAR: key_ready=1; one accepted bit SHALL complete even parity over KEY_W+1 bits; a match SHALL go to HOLD, a mismatch to ERR.
REQ-021 On entry to HOLD, key_out SHALL load shreg; key_out SHALL change at no other time except in reset and LOCKOUT.
REQ-022 HOLD: fsm_rst=1 for exactly HOLD_CYC cycles, then a transition to RUN.
REQ-023 RUN: fsm_rst=0 and active=1; start SHALL re-enter LOAD (rekey) and increment try_cnt.
REQ-024 ERR: err=1 and fsm_rst=1; start SHALL go to LOAD and increment try_cnt; err SHALL clear on LOAD entry.
REQ-025 start received in IDLE, RUN or ERR with try_cnt==MAX_TRIES SHALL go to LOCKOUT instead of LOAD.
REQ-026 LOCKOUT: key_out=0, fsm_rst=1, lockout=1, key_ready=0; exit only by reset.
REQ-027 fsm_rst SHALL be 1 in IDLE, LOAD and PAR, so the locked controller never runs with a partial key.
REQ-028 abort in LOAD or PAR SHALL return to IDLE and discard shreg; the try is still consumed; abort has priority over a simultaneous key_valid.
REQ-029 In HOLD, RUN, ERR and IDLE, abort SHALL be ignored, and key_valid SHALL be ignored outside LOAD and PAR.
REQ-030 try_cnt SHALL be a ceil(log2(MAX_TRIES+1))-bit counter that saturates at MAX_TRIES and never wraps.

Reset
REQ-031 When rst=0: state=IDLE, shreg=0, key_out=0, counters=0, fsm_rst=1, key_ready=0, active=0, err=0 and lockout=0, immediately and independent of clk.
REQ-032 Reset asserted mid-session SHALL abandon the session with no partial key_out update.

Configuration
REQ-033 Macro ROBM_KEY_PARITY_EN SHALL control parity checking.
REQ-034 With ROBM_KEY_PARITY_EN defined, the PAR state and the err path SHALL exist.
REQ-035 Without ROBM_KEY_PARITY_EN, PAR and ERR SHALL be absent, LOAD SHALL go directly to HOLD, and err SHALL be tied to 0.

Structure
REQ-036 A shared package robm_pkg SHALL hold the state enum, the default KEY_W, MAX_TRIES and HOLD_CYC constants, and the parity function.
REQ-037 A single sub-module robm_key_shreg SHALL implement the serial shift register with its bit counter and done flag; the rest SHALL be flat.

Verification
REQ-038 Reset, start, key bits 1,0,1,1,0,0,1,0 plus parity bit 0 -> key_out=8'hB2 at HOLD entry, fsm_rst=1 for 4 cycles, then active=1.
REQ-039 The same key with parity bit 1 -> ERR, err=1, key_out unchanged (0), fsm_rst=1.
REQ-040 abort after 3 bits with key_valid=1 in the same cycle -> IDLE, shreg cleared, try_cnt=1.
REQ-041 Three sessions, then a fourth start -> LOCKOUT, key_out=0, lockout=1; further start has no effect until rst=0.
REQ-042 rst=0 asserted during HOLD with clk stopped -> outputs reach their reset values immediately.
REQ-043 Build without the macro, 8 key bits -> HOLD directly, with no ninth bit accepted.
